dct_transpose_seq: RTL and testbench

Sequencer and storage for the 8×8 transpose stage between the row and column 1-D DCT passes. It accepts 64 row-major samples over a valid/ready handshake and writes each one into a 64-entry register array. The write target is chosen by a 6-bit address decoded to a one-hot row enable in the 6-to-64 style. Once full, it drains the block in column-major order (or zigzag order, see Configuration), then refills.

---
 rtl/dct_transpose_seq.sv | 143 ++++++++++++++
 tb/tb_dct_transpose_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_transpose_seq.sv
// 8x8 transpose buffer between the row and column DCT passes: fills 64 samples
// row-major, then drains column-major (or JPEG zigzag when ZIGZAG_OUT_EN is defined).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FILL  | accepting row-major samples into mem[wr_cnt], in_ready=1
// S_DRAIN | presenting mem[rd_addr] downstream, out_valid=1
module dct_transpose_seq #(
    parameter int DATA_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [5:0]        wr_addr,
    output logic              busy
);

    localparam logic [0:0] S_FILL  = 1'b0;
    localparam logic [0:0] S_DRAIN = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [5:0]        wr_cnt;
    logic [5:0]        wr_cnt_nxt;
    logic [5:0]        rd_cnt;
    logic [5:0]        rd_cnt_nxt;
    logic [5:0]        rd_addr;
    logic              wr_fire;
    logic              rd_fire;
    logic [63:0]       wr_onehot;
    logic [63:0]       wr_en;
    logic [DATA_W-1:0] mem [64];

    assign in_ready  = (state == S_FILL);
    assign out_valid = (state == S_DRAIN);
    assign wr_addr   = wr_cnt;
    assign busy      = out_valid | (wr_cnt != 6'd0);
    assign out_last  = out_valid & (rd_cnt == 6'd63);

    // flush wins over a same-cycle handshake, so neither side may count it
    assign wr_fire = in_valid & in_ready & ~flush;
    assign rd_fire = out_valid & out_ready & ~flush;

    assign wr_onehot = 64'd1 << wr_cnt;
    assign wr_en     = wr_onehot & {64{wr_fire}};

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        if (flush) begin
            state_nxt  = S_FILL;
            wr_cnt_nxt = 6'd0;
            rd_cnt_nxt = 6'd0;
        end else begin
            case (state)
                S_FILL: begin
                    if (wr_fire) begin
                        wr_cnt_nxt = wr_cnt + 6'd1;
                        if (wr_cnt == 6'd63) begin
                            rd_cnt_nxt = 6'd0;
                            state_nxt  = S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (rd_fire) begin
                        rd_cnt_nxt = rd_cnt + 6'd1;
                        if (rd_cnt == 6'd63) begin
                            state_nxt = S_FILL;
                        end
                    end
                end
                default: state_nxt = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_FILL;
            wr_cnt <= 6'd0;
            rd_cnt <= 6'd0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_cnt_nxt;
            rd_cnt <= rd_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (wr_en[i]) begin
                    mem[i] <= in_data;
                end
            end
        end
    end

`ifdef ZIGZAG_OUT_EN
    // Standard JPEG zigzag scan: scan index -> row-major position
    always_comb begin
        rd_addr = 6'd0;
        case (rd_cnt)
            6'd0:  rd_addr = 6'd0;   6'd1:  rd_addr = 6'd1;   6'd2:  rd_addr = 6'd8;   6'd3:  rd_addr = 6'd16;
            6'd4:  rd_addr = 6'd9;   6'd5:  rd_addr = 6'd2;   6'd6:  rd_addr = 6'd3;   6'd7:  rd_addr = 6'd10;
            6'd8:  rd_addr = 6'd17;  6'd9:  rd_addr = 6'd24;  6'd10: rd_addr = 6'd32;  6'd11: rd_addr = 6'd25;
            6'd12: rd_addr = 6'd18;  6'd13: rd_addr = 6'd11;  6'd14: rd_addr = 6'd4;   6'd15: rd_addr = 6'd5;
            6'd16: rd_addr = 6'd12;  6'd17: rd_addr = 6'd19;  6'd18: rd_addr = 6'd26;  6'd19: rd_addr = 6'd33;
            6'd20: rd_addr = 6'd40;  6'd21: rd_addr = 6'd48;  6'd22: rd_addr = 6'd41;  6'd23: rd_addr = 6'd34;
            6'd24: rd_addr = 6'd27;  6'd25: rd_addr = 6'd20;  6'd26: rd_addr = 6'd13;  6'd27: rd_addr = 6'd6;
            6'd28: rd_addr = 6'd7;   6'd29: rd_addr = 6'd14;  6'd30: rd_addr = 6'd21;  6'd31: rd_addr = 6'd28;
            6'd32: rd_addr = 6'd35;  6'd33: rd_addr = 6'd42;  6'd34: rd_addr = 6'd49;  6'd35: rd_addr = 6'd56;
            6'd36: rd_addr = 6'd57;  6'd37: rd_addr = 6'd50;  6'd38: rd_addr = 6'd43;  6'd39: rd_addr = 6'd36;
            6'd40: rd_addr = 6'd29;  6'd41: rd_addr = 6'd22;  6'd42: rd_addr = 6'd15;  6'd43: rd_addr = 6'd23;
            6'd44: rd_addr = 6'd30;  6'd45: rd_addr = 6'd37;  6'd46: rd_addr = 6'd44;  6'd47: rd_addr = 6'd51;
            6'd48: rd_addr = 6'd58;  6'd49: rd_addr = 6'd59;  6'd50: rd_addr = 6'd52;  6'd51: rd_addr = 6'd45;
            6'd52: rd_addr = 6'd38;  6'd53: rd_addr = 6'd31;  6'd54: rd_addr = 6'd39;  6'd55: rd_addr = 6'd46;
            6'd56: rd_addr = 6'd53;  6'd57: rd_addr = 6'd60;  6'd58: rd_addr = 6'd61;  6'd59: rd_addr = 6'd54;
            6'd60: rd_addr = 6'd47;  6'd61: rd_addr = 6'd55;  6'd62: rd_addr = 6'd62;  6'd63: rd_addr = 6'd63;
            default: rd_addr = 6'd0;
        endcase
    end
`else
    // Swapping the row/column fields of the scan index gives the transpose
    assign rd_addr = {rd_cnt[2:0], rd_cnt[5:3]};
`endif

    assign out_data = mem[rd_addr];

endmodule

// File: tb/tb_dct_transpose_seq.sv
// Directed bench for dct_transpose_seq: transpose order, stalls, flush and async reset.
// Expected order follows ZIGZAG_OUT_EN when the bench is built with it.
module tb_dct_transpose_seq;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_last;
    logic [5:0]  wr_addr;
    logic        busy;

    int tests_run;
    int tests_failed;

    logic [11:0] blk [64];

`ifdef ZIGZAG_OUT_EN
    int zz_tab [64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63 };
`endif

    dct_transpose_seq #(.DATA_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .wr_addr   (wr_addr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row-major position expected at output position k
    function automatic int exp_addr(input int k);
`ifdef ZIGZAG_OUT_EN
        return zz_tab[k];
`else
        return (k % 8) * 8 + (k / 8);
`endif
    endfunction

    // Stimulus only: pushes blk[0..63], returns at the negedge after the last handshake
    task automatic fill_block(input bit gaps);
        int k;
        int guard;
        bit v;
        k = 0;
        guard = 0;
        while (k < 64 && guard < 1000) begin
            @(negedge clk);
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid = v;
            in_data  = blk[k];
            if (v) k++;
            guard++;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 ||
            wr_addr !== 6'd0 || busy !== 1'b0 || out_data !== 12'd0) begin
            tests_failed++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b out_last=%b wr_addr=%0d busy=%b out_data=%0h, want 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, wr_addr, busy, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_transpose;
        for (int k = 0; k < 64; k++) blk[k] = 12'(k);
        out_ready = 1'b1;
        fill_block(1'b0);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency: out_valid=%b in_ready=%b busy=%b, want 1 0 1", out_valid, in_ready, busy);
        end
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            // in_valid held high during drain must be ignored
            in_valid = (k < 63);
            in_data  = 12'hABC;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== blk[exp_addr(k)] || out_last !== (k == 63)) begin
                tests_failed++;
                $display("FAIL transpose_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         k, out_valid, out_data, out_last, blk[exp_addr(k)], (k == 63));
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || wr_addr !== 6'd0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill_ready: in_ready=%b out_valid=%b busy=%b wr_addr=%0d last=%b, want 1 0 0 0 0",
                     in_ready, out_valid, busy, wr_addr, out_last);
        end
    endtask

    task automatic test_stall_two_blocks;
        int idx;
        int cyc;
        bit prev_stall;
        logic [11:0] prev_data;
        logic prev_last;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = (b == 0) ? 12'(100 + k) : 12'(-1 - k);
            fill_block(1'b1);
            idx = 0;
            cyc = 0;
            prev_stall = 1'b0;
            prev_data = '0;
            prev_last = 1'b0;
            while (idx < 64 && cyc < 400) begin
                if (cyc > 0) @(negedge clk);
                if (prev_stall) begin
                    tests_run++;
                    if (out_data !== prev_data || out_last !== prev_last) begin
                        tests_failed++;
                        $display("FAIL stall_hold b%0d i%0d: data=%0h last=%b, want %0h %b",
                                 b, idx, out_data, out_last, prev_data, prev_last);
                    end
                end
                out_ready = (cyc % 2 == 0);
                if (out_valid !== 1'b1) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL stall_valid b%0d i%0d: out_valid=%b, want 1", b, idx, out_valid);
                    break;
                end
                if (out_ready) begin
                    tests_run++;
                    if (out_data !== blk[exp_addr(idx)] || out_last !== (idx == 63)) begin
                        tests_failed++;
                        $display("FAIL stall_out b%0d[%0d]: data=%0h last=%b, want %0h %b",
                                 b, idx, out_data, out_last, blk[exp_addr(idx)], (idx == 63));
                    end
                    idx++;
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_last  = out_last;
                cyc++;
            end
            tests_run++;
            if (idx != 64) begin
                tests_failed++;
                $display("FAIL stall_count b%0d: drained %0d, want 64", b, idx);
            end
            @(negedge clk);
            out_ready = 1'b1;
            tests_run++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_refill b%0d: in_ready=%b out_valid=%b, want 1 0", b, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_flush_fill;
        for (int k = 0; k < 64; k++) blk[k] = 12'(7 + 3 * k);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = blk[k];
        end
        @(negedge clk);
        tests_run++;
        if (wr_addr !== 6'd20 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_fill_pre: wr_addr=%0d busy=%b, want 20 1", wr_addr, busy);
        end
        in_valid = 1'b1;
        in_data  = 12'h3E7;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        tests_run++;
        if (wr_addr !== 6'd0 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_fill_post: wr_addr=%0d in_ready=%b busy=%b out_valid=%b, want 0 1 0 0",
                     wr_addr, in_ready, busy, out_valid);
        end
        out_ready = 1'b1;
        fill_block(1'b0);
        for (int k = 0; k < 64; k++) begin
            if (k > 0) @(negedge clk);
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== blk[exp_addr(k)] || out_last !== (k == 63)) begin
                tests_failed++;
                $display("FAIL flush_fill_out[%0d]: valid=%b data=%0d last=%b, want 1 %0d %b",
                         k, out_valid, out_data, out_last, blk[exp_addr(k)], (k == 63));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flush_drain;
        bit saw_last;
        saw_last = 1'b0;
        for (int k = 0; k < 64; k++) blk[k] = 12'(500 + k);
        out_ready = 1'b1;
        fill_block(1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            if (out_last) saw_last = 1'b1;
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== blk[exp_addr(k)]) begin
                tests_failed++;
                $display("FAIL flush_drain_out[%0d]: valid=%b data=%0d, want 1 %0d",
                         k, out_valid, out_data, blk[exp_addr(k)]);
            end
        end
        @(negedge clk);
        if (out_last) saw_last = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (out_last) saw_last = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || wr_addr !== 6'd0 || busy !== 1'b0 || saw_last) begin
            tests_failed++;
            $display("FAIL flush_drain_post: out_valid=%b in_ready=%b wr_addr=%0d busy=%b saw_last=%b, want 0 1 0 0 0",
                     out_valid, in_ready, wr_addr, busy, saw_last);
        end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 64; k++) blk[k] = 12'(900 + k);
        out_ready = 1'b1;
        fill_block(1'b0);
        repeat (5) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data === 12'd0) begin
            tests_failed++;
            $display("FAIL areset_pre: out_valid=%b out_data=%0d, want 1 and nonzero", out_valid, out_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 12'd0 || busy !== 1'b0 || in_ready !== 1'b1 || wr_addr !== 6'd0) begin
            tests_failed++;
            $display("FAIL areset_now: out_valid=%b out_data=%0d busy=%b in_ready=%b wr_addr=%0d, want 0 0 0 1 0",
                     out_valid, out_data, busy, in_ready, wr_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        test_reset();
        test_transpose();
        test_stall_two_blocks();
        test_flush_fill();
        test_flush_drain();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
